tile_spawner: RTL and testbench

Parametrised random-tile spawner for the 2048 game core. On request, it snapshots the board, counts empty cells, picks one uniformly using a free-running LFSR, and issues a single write of a 2 or a 4 into it. Spawn latency is bounded; there is no retry loop. It also raises a game-over flag when no spawn is possible. It sits between the move/merge logic, which requests a spawn after every valid move, and the board register file, which accepts the write port.

---
 rtl/tfe_pkg.sv | 21 ++
 rtl/tfe_lfsr.sv | 27 ++
 rtl/tile_spawner.sv | 224 ++++++++++++++++++++++
 tb/tb_tile_spawner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tfe_pkg.sv
// Shared types and constants for the 2048 tile spawner.
package tfe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          TILE_TWO     = 2;
    localparam int          TILE_FOUR    = 4;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/tfe_lfsr.sv
// Free-running 16-bit Galois LFSR; a zero seed falls back to DEFAULT_SEED.
module tfe_lfsr
    import tfe_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] state_r;

    // Advance every cycle; never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= INIT;
        end else begin
            state_r <= lfsr_step(state_r);
        end
    end

    assign q = state_r;

endmodule

// File: rtl/tile_spawner.sv
// Random-tile spawner: snapshot, pick the T-th empty cell, write a 2 or a 4.
// Optional feature macro: TILE_SPAWNER_MERGE_CHECK_EN (full board with a legal merge is not game over).
module tile_spawner
    import tfe_pkg::*;
#(
    parameter int          ROWS      = 4,
    parameter int          COLS      = 4,
    parameter int          VAL_W     = 21,
    parameter int          FOUR_ODDS = 10,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              spawn_req,
    input  logic [ROWS*COLS*VAL_W-1:0]        board_flat,
    output logic                              busy,
    output logic                              wr_en,
    output logic [$clog2(ROWS*COLS)-1:0]      wr_idx,
    output logic [VAL_W-1:0]                  wr_val,
    output logic                              done,
    output logic                              game_over
);

    localparam int CELLS  = ROWS * COLS;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int CNT_W  = IDX_W + 1;
    localparam int PROD_W = 8 + IDX_W + 1;
    localparam int ODDS_W = 17;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    logic [15:0]      lfsr_s;
    logic [CELLS-1:0] empty_vec_s;
    logic [CNT_W-1:0] empty_cnt_s;
    logic [CNT_W-1:0] target_s;
    logic             four_s;
    logic             merge_s;
    logic             hit_s;

    state_e           state_r;
    state_e           state_next_s;
    logic [CELLS-1:0] empty_snap_r;
    logic [CNT_W-1:0] t_r;
    logic [CNT_W-1:0] seen_r;
    logic [IDX_W-1:0] p_r;
    logic [IDX_W-1:0] idx_r;
    logic             four_r;

    logic             busy_r, wr_en_r, done_r, game_over_r;
    logic [IDX_W-1:0] wr_idx_r;
    logic [VAL_W-1:0] wr_val_r;
    logic             busy_next_s, wr_en_next_s, done_next_s, game_over_next_s;
    logic [IDX_W-1:0] wr_idx_next_s;
    logic [VAL_W-1:0] wr_val_next_s;

    tfe_lfsr #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_s)
    );

    // Empty-cell map and popcount of the live board, used at acceptance.
    always_comb begin
        empty_vec_s = {CELLS{1'b0}};
        empty_cnt_s = {CNT_W{1'b0}};
        for (int i = 0; i < CELLS; i++) begin
            empty_vec_s[i] = (board_flat[i*VAL_W +: VAL_W] == {VAL_W{1'b0}});
            empty_cnt_s    = empty_cnt_s + CNT_W'(empty_vec_s[i]);
        end
    end

    // Scaling R by E keeps T strictly below E without a divider.
    assign target_s = CNT_W'((PROD_W'(lfsr_s[7:0]) * PROD_W'(empty_cnt_s)) >> 4'd8);
    assign four_s   = (((ODDS_W'(lfsr_s[15:8]) * ODDS_W'(FOUR_ODDS)) >> 4'd8) == {ODDS_W{1'b0}});

`ifdef TILE_SPAWNER_MERGE_CHECK_EN
    // Any equal horizontal or vertical neighbour pair means a move is still possible.
    always_comb begin
        merge_s = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS - 1; c++) begin
                merge_s = merge_s | (board_flat[(r*COLS+c)*VAL_W +: VAL_W] ==
                                     board_flat[(r*COLS+c+1)*VAL_W +: VAL_W]);
            end
        end
        for (int r = 0; r < ROWS - 1; r++) begin
            for (int c = 0; c < COLS; c++) begin
                merge_s = merge_s | (board_flat[(r*COLS+c)*VAL_W +: VAL_W] ==
                                     board_flat[((r+1)*COLS+c)*VAL_W +: VAL_W]);
            end
        end
    end
`else
    assign merge_s = 1'b0;
`endif

    assign hit_s = empty_snap_r[p_r] && (seen_r == t_r);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (spawn_req) begin
                    state_next_s = (empty_cnt_s == {CNT_W{1'b0}}) ? ST_DONE : ST_SCAN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (hit_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_WRITE: state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM output logic; values land in the output registers one cycle later.
    always_comb begin
        busy_next_s      = (state_r != ST_IDLE);
        wr_en_next_s     = (state_r == ST_WRITE);
        done_next_s      = (state_r == ST_DONE);
        wr_idx_next_s    = wr_idx_r;
        wr_val_next_s    = wr_val_r;
        game_over_next_s = game_over_r;
        case (state_r)
            ST_IDLE: begin
                if (spawn_req && (empty_cnt_s == {CNT_W{1'b0}}) && !merge_s) begin
                    game_over_next_s = 1'b1;
                end else begin
                    game_over_next_s = game_over_r;
                end
            end
            ST_WRITE: begin
                wr_idx_next_s    = idx_r;
                wr_val_next_s    = four_r ? VAL_W'(TILE_FOUR) : VAL_W'(TILE_TWO);
                game_over_next_s = 1'b0;
            end
            default: begin
                game_over_next_s = game_over_r;
            end
        endcase
    end

    // Registered outputs; wr_idx/wr_val hold until the next write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r      <= 1'b0;
            wr_en_r     <= 1'b0;
            done_r      <= 1'b0;
            wr_idx_r    <= {IDX_W{1'b0}};
            wr_val_r    <= {VAL_W{1'b0}};
            game_over_r <= 1'b0;
        end else begin
            busy_r      <= busy_next_s;
            wr_en_r     <= wr_en_next_s;
            done_r      <= done_next_s;
            wr_idx_r    <= wr_idx_next_s;
            wr_val_r    <= wr_val_next_s;
            game_over_r <= game_over_next_s;
        end
    end

    // Request snapshot and the cell-by-cell scan datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            empty_snap_r <= {CELLS{1'b0}};
            t_r          <= {CNT_W{1'b0}};
            seen_r       <= {CNT_W{1'b0}};
            p_r          <= {IDX_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            four_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (spawn_req) begin
                        empty_snap_r <= empty_vec_s;
                        t_r          <= target_s;
                        four_r       <= four_s;
                        seen_r       <= {CNT_W{1'b0}};
                        p_r          <= {IDX_W{1'b0}};
                    end
                end
                ST_SCAN: begin
                    if (hit_s) begin
                        idx_r <= p_r;
                    end else begin
                        if (empty_snap_r[p_r]) begin
                            seen_r <= seen_r + CNT_W'(1'b1);
                        end
                        // T < E guarantees a hit before the last cell is passed.
                        if (p_r != LAST_IDX) begin
                            p_r <= p_r + IDX_W'(1'b1);
                        end
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign wr_en     = wr_en_r;
    assign done      = done_r;
    assign wr_idx    = wr_idx_r;
    assign wr_val    = wr_val_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_tile_spawner.sv
// Directed self-checking bench for tile_spawner (4x4, VAL_W=21, FOUR_ODDS=10, SEED=16'hACE1).
module tb_tile_spawner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int VAL_W = 21;
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = 4;
    localparam int BW    = N * VAL_W;
    localparam int STAT_SPAWNS = 3000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             spawn_req = 1'b0;
    logic [BW-1:0]    board_flat = '0;
    logic             busy, wr_en, done, game_over;
    logic [IDX_W-1:0] wr_idx;
    logic [VAL_W-1:0] wr_val;

    int checks = 0;
    int failures = 0;
    logic [15:0] model_lfsr;

    tile_spawner #(
        .ROWS(ROWS), .COLS(COLS), .VAL_W(VAL_W), .FOUR_ODDS(10), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .spawn_req(spawn_req), .board_flat(board_flat),
        .busy(busy), .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
        .done(done), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Reference LFSR: Galois, mask 0xB400, shift right, reset to the seed.
    always @(posedge clk or negedge rst) begin
        if (!rst) model_lfsr <= 16'hACE1;
        else      model_lfsr <= {1'b0, model_lfsr[15:1]} ^ (model_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_target(input logic [15:0] l, input int e);
        return (int'(l[7:0]) * e) >> 8;
    endfunction

    function automatic int exp_value(input logic [15:0] l);
        return (((int'(l[15:8]) * 10) >> 8) == 0) ? 4 : 2;
    endfunction

    function automatic logic [BW-1:0] set_cell(input logic [BW-1:0] b, input int idx, input int v);
        logic [BW-1:0] r;
        r = b;
        r[idx*VAL_W +: VAL_W] = VAL_W'(v);
        return r;
    endfunction

    // Issue one request from a negedge; report observations in cycles after the acceptance edge.
    task automatic do_spawn(input logic [BW-1:0] b, input logic [BW-1:0] b_after,
                            output int n_wr, output int idx, output int val,
                            output int wr_cyc, output int done_cyc,
                            output logic go_done, output logic go_prewr,
                            output logic busy_ok, output logic [15:0] l_acc);
        n_wr = 0; idx = -1; val = 0; wr_cyc = -1; done_cyc = -1;
        go_done = 1'b0; busy_ok = 1'b1;
        board_flat = b;
        spawn_req  = 1'b1;
        l_acc      = model_lfsr;
        @(posedge clk);
        @(negedge clk);
        spawn_req  = 1'b0;
        board_flat = b_after;
        go_prewr   = game_over;
        for (int n = 1; n <= 40 && done_cyc < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (wr_en) begin
                n_wr++;
                idx = int'(wr_idx);
                val = int'(wr_val);
                wr_cyc = n;
            end else if (n_wr == 0) begin
                go_prewr = game_over;
            end
            if (done) begin
                done_cyc = n;
                go_done  = game_over;
            end
        end
        check_eq("done_within_bound", done_cyc >= 0, 1);
    endtask

    initial begin
        logic [BW-1:0] full_b, cell3_b, merge_b, last_b;
        int n_wr, idx, val, wr_cyc, done_cyc, t, wr_seen;
        logic go_done, go_prewr, busy_ok;
        logic [15:0] l_acc;
        int hist[N];
        int fours;

        full_b = '0;
        for (int i = 0; i < N; i++) full_b = set_cell(full_b, i, 1 << (i + 1));
        cell3_b = set_cell(full_b, 3, 0);
        last_b  = '0;
        for (int i = 0; i < N - 1; i++) last_b = set_cell(last_b, i, 2);
        merge_b = '0;
        for (int i = 2; i < N; i++) merge_b = set_cell(merge_b, i, 1 << (i + 2));
        merge_b = set_cell(merge_b, 0, 8);
        merge_b = set_cell(merge_b, 1, 8);

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wr_idx", wr_idx, 0);
        check_eq("rst_wr_val", wr_val, 0);
        check_eq("rst_game_over", game_over, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Empty board: one write at the modelled index and value
        do_spawn('0, '0, n_wr, idx, val, wr_cyc, done_cyc, go_done, go_prewr, busy_ok, l_acc);
        t = exp_target(l_acc, 16);
        check_eq("empty_n_wr", n_wr, 1);
        check_eq("empty_idx", idx, t);
        check_eq("empty_val", val, exp_value(l_acc));
        check_eq("empty_wr_cycle", wr_cyc, 2 + t);
        check_eq("empty_done_cycle", done_cyc, 3 + t);
        check_eq("empty_busy_held", busy_ok, 1);
        check_eq("empty_game_over", go_done, 0);
        @(negedge clk);
        check_eq("empty_busy_after", busy, 0);

        // Only cell 15 empty; board change after acceptance must be ignored
        do_spawn(last_b, full_b, n_wr, idx, val, wr_cyc, done_cyc, go_done, go_prewr, busy_ok, l_acc);
        check_eq("last_n_wr", n_wr, 1);
        check_eq("last_idx", idx, 15);
        check_eq("last_wr_cycle", wr_cyc, 17);
        check_eq("last_val", val, exp_value(l_acc));
        check_eq("last_game_over", go_done, 0);

        // Full board of distinct tiles
        do_spawn(full_b, full_b, n_wr, idx, val, wr_cyc, done_cyc, go_done, go_prewr, busy_ok, l_acc);
        check_eq("full_done_cycle", done_cyc, 1);
        check_eq("full_n_wr", n_wr, 0);
        check_eq("full_game_over", go_done, 1);
        check_eq("full_wr_idx_held", wr_idx, 15);

        // Next request with cell 3 empty clears game_over in the write cycle
        do_spawn(cell3_b, cell3_b, n_wr, idx, val, wr_cyc, done_cyc, go_done, go_prewr, busy_ok, l_acc);
        check_eq("c3_idx", idx, 3);
        check_eq("c3_wr_cycle", wr_cyc, 5);
        check_eq("c3_go_before_write", go_prewr, 1);
        check_eq("c3_go_at_done", go_done, 0);
        check_eq("c3_val", val, exp_value(l_acc));

        // Full board with a legal merge between cells 0 and 1
        do_spawn(merge_b, merge_b, n_wr, idx, val, wr_cyc, done_cyc, go_done, go_prewr, busy_ok, l_acc);
        check_eq("merge_done_cycle", done_cyc, 1);
        check_eq("merge_n_wr", n_wr, 0);
`ifdef TILE_SPAWNER_MERGE_CHECK_EN
        check_eq("merge_game_over", go_done, 0);
`else
        check_eq("merge_game_over", go_done, 1);
`endif

        // Reset asserted during SCAN abandons the request
        board_flat = last_b;
        spawn_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        spawn_req = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_wr_en", wr_en, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_wr_idx", wr_idx, 0);
        check_eq("mid_rst_wr_val", wr_val, 0);
        check_eq("mid_rst_game_over", game_over, 0);
        @(negedge clk);
        rst = 1'b1;
        wr_seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
        end
        check_eq("mid_rst_no_write", wr_seen, 0);

        // Distribution on an empty board, every spawn also checked against the model
        for (int i = 0; i < N; i++) hist[i] = 0;
        fours = 0;
        for (int s = 0; s < STAT_SPAWNS; s++) begin
            do_spawn('0, '0, n_wr, idx, val, wr_cyc, done_cyc, go_done, go_prewr, busy_ok, l_acc);
            check_eq("stat_idx", idx, exp_target(l_acc, 16));
            check_eq("stat_val", val, exp_value(l_acc));
            if (idx >= 0 && idx < N) hist[idx]++;
            if (val == 4) fours++;
        end
        for (int i = 0; i < N; i++) begin
            check_eq("stat_cell_uniform", (hist[i] >= 140 && hist[i] <= 235), 1);
        end
        check_eq("stat_four_rate", (fours >= 210 && fours <= 390), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
